// File: rtl/ball_motion_ctrl.sv
// Per-frame ball mover: steps x then y one pixel per clock, stopping on
// collision flags or the screen edge, and reports done/hit at the end.

module ball_axis_eval #(
  parameter int LIM = 640
) (
  input  logic [10:0] pos,
  input  logic [10:0] size,
  input  logic        en,
  input  logic        neg,
  input  logic [2:0]  cnt,
  input  logic        stop_pos,
  input  logic        stop_neg,
  output logic        go,
  output logic        blk
);
  logic active, at_edge;

  always_comb begin
    active  = en && (cnt != 3'd0);
    blk     = active && (neg ? stop_neg : stop_pos);
    // 12-bit sum so a wide ball near the right edge cannot wrap the compare
    at_edge = neg ? (pos == 11'd0)
                  : (({1'b0, pos} + {1'b0, size}) >= 12'(LIM));
    go      = active && !blk && !at_edge;
  end
endmodule

module ball_motion_ctrl #(
  parameter int START_X = 40,
  parameter int START_Y = 60,
  parameter int H_MAX   = 640,
  parameter int V_MAX   = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        restart,
  input  logic        dir_right,
  input  logic        dir_left,
  input  logic        dir_up,
  input  logic        dir_down,
  input  logic [2:0]  speed,
  input  logic [4:0]  ball_width,
  input  logic        stop_right,
  input  logic        stop_left,
  input  logic        stop_up,
  input  logic        stop_down,
  output logic [10:0] x_ball,
  output logic [10:0] y_ball,
  output logic        busy,
  output logic        done,
  output logic        hit
);
  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, DONE} state_t;

  state_t      state;
  logic        x_en, x_neg, y_en, y_neg;
  logic [2:0]  cnt_x, cnt_y;
  logic        hit_acc;
  logic        x_go, x_blk, y_go, y_blk;
  logic [10:0] bw;

  assign bw = {6'd0, ball_width};

  ball_axis_eval #(.LIM(H_MAX)) u_ax_x (
    .pos(x_ball), .size(bw), .en(x_en), .neg(x_neg), .cnt(cnt_x),
    .stop_pos(stop_right), .stop_neg(stop_left), .go(x_go), .blk(x_blk)
  );

  ball_axis_eval #(.LIM(V_MAX)) u_ax_y (
    .pos(y_ball), .size(bw), .en(y_en), .neg(y_neg), .cnt(cnt_y),
    .stop_pos(stop_down), .stop_neg(stop_up), .go(y_go), .blk(y_blk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x_ball  <= 11'(START_X);
      y_ball  <= 11'(START_Y);
      x_en    <= 1'b0;
      x_neg   <= 1'b0;
      y_en    <= 1'b0;
      y_neg   <= 1'b0;
      cnt_x   <= 3'd0;
      cnt_y   <= 3'd0;
      hit_acc <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hit     <= 1'b0;
    end else if (restart) begin
      state   <= IDLE;
      x_ball  <= 11'(START_X);
      y_ball  <= 11'(START_Y);
      cnt_x   <= 3'd0;
      cnt_y   <= 3'd0;
      hit_acc <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hit     <= 1'b0;
    end else begin
      done <= 1'b0;
      hit  <= 1'b0;
      case (state)
        IDLE: if (frame_tick) begin
          // opposing requests on an axis cancel to zero motion
          x_en    <= dir_right ^ dir_left;
          x_neg   <= dir_left;
          y_en    <= dir_down ^ dir_up;
          y_neg   <= dir_up;
          cnt_x   <= speed;
          cnt_y   <= speed;
          hit_acc <= 1'b0;
          busy    <= 1'b1;
          state   <= STEP_X;
        end
        STEP_X: begin
          if (x_go) begin
            x_ball <= x_neg ? x_ball - 11'd1 : x_ball + 11'd1;
            cnt_x  <= cnt_x - 3'd1;
          end else begin
            if (x_blk) hit_acc <= 1'b1;
            cnt_x <= 3'd0;
            state <= STEP_Y;
          end
        end
        STEP_Y: begin
          if (y_go) begin
            y_ball <= y_neg ? y_ball - 11'd1 : y_ball + 11'd1;
            cnt_y  <= cnt_y - 3'd1;
          end else begin
            // a block on this final step must still reach the hit pulse
            if (y_blk) hit_acc <= 1'b1;
            cnt_y <= 3'd0;
            done  <= 1'b1;
            hit   <= hit_acc | y_blk;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: table of frame moves checked through a
// done-driven scoreboard, plus reset/restart/overlap sequences.

module tb_ball_motion_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0, restart = 1'b0;
  logic        dir_right = 1'b0, dir_left = 1'b0, dir_up = 1'b0, dir_down = 1'b0;
  logic [2:0]  speed = 3'd0;
  logic [4:0]  ball_width = 5'd8;
  logic        stop_right, stop_left, stop_up, stop_down;
  logic [10:0] x_ball, y_ball;
  logic        busy, done, hit;
  logic        wall_en = 1'b0;

  int errors = 0, checks = 0, cyc = 0, done_cnt = 0;

  typedef struct { int x; int y; int hit; int lat; int tc; } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic r, l, u, d, wall, rs;
    int spd, x, y, hit, lat;
  } vec_t;
  vec_t tbl[9];

  // collision stage model: a wall whose right face sits at x = 29
  assign stop_left  = wall_en && (x_ball == 11'd29);
  assign stop_right = 1'b0;
  assign stop_up    = 1'b0;
  assign stop_down  = 1'b0;

  ball_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .restart(restart),
    .dir_right(dir_right), .dir_left(dir_left), .dir_up(dir_up), .dir_down(dir_down),
    .speed(speed), .ball_width(ball_width),
    .stop_right(stop_right), .stop_left(stop_left), .stop_up(stop_up), .stop_down(stop_down),
    .x_ball(x_ball), .y_ball(y_ball), .busy(busy), .done(done), .hit(hit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("x_ball", int'(x_ball), e.x);
        chk("y_ball", int'(y_ball), e.y);
        chk("hit", int'(hit), e.hit);
        chk("latency", cyc - e.tc, e.lat);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", 0, 1);
      sbq.delete();
    end
  endtask

  task automatic run_frame(input logic r, l, u, d, input int spd, ex, ey, eh, el);
    exp_t e;
    @(negedge clk);
    {dir_right, dir_left, dir_up, dir_down} = {r, l, u, d};
    speed = 3'(spd);
    frame_tick = 1'b1;
    e = '{x: ex, y: ey, hit: eh, lat: el, tc: cyc};
    sbq.push_back(e);
    @(negedge clk);
    frame_tick = 1'b0;
    chk("busy_after_tick", int'(busy), 1);
    // mid-move input changes must have no effect
    {dir_right, dir_left, dir_up, dir_down} = 4'($urandom);
    speed = 3'($urandom);
    wait_drain();
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  initial begin
    int base, ye, xe;
    exp_t e;
    //          r    l    u    d   wall  rs   spd  x    y   hit lat
    tbl[0] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 5,  45,  65, 0, 13};
    tbl[1] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 7,  33,  60, 0, 10};
    tbl[2] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 7,  29,  60, 1,  7};
    tbl[3] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 7,  29,  60, 1,  3};
    tbl[4] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 3,  29,  57, 0,  6};
    tbl[5] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 0,  29,  57, 0,  3};
    tbl[6] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 7,  29,  50, 0, 10};
    tbl[7] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 7,  29,  50, 0,  3};
    tbl[8] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 7,  29,  57, 0, 10};

    repeat (3) @(negedge clk);
    chk("rst_x", int'(x_ball), 40);
    chk("rst_y", int'(y_ball), 60);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hit", int'(hit), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      wall_en = tbl[i].wall;
      if (tbl[i].rs) begin
        pulse_restart();
        chk("restart_x", int'(x_ball), 40);
        chk("restart_y", int'(y_ball), 60);
      end
      run_frame(tbl[i].r, tbl[i].l, tbl[i].u, tbl[i].d, tbl[i].spd,
                tbl[i].x, tbl[i].y, tbl[i].hit, tbl[i].lat);
    end
    wall_en = 1'b0;

    // walk right to x = 630, then clamp at 640 - 8
    xe = 29;
    for (int k = 0; k < 85; k++) begin
      xe += 7;
      run_frame(1, 0, 0, 0, 7, xe, 57, 0, 10);
    end
    run_frame(1, 0, 0, 0, 6, 630, 57, 0, 9);
    run_frame(1, 0, 0, 0, 7, 632, 57, 0, 5);

    // walk up to y = 2, then clamp at 0
    ye = 57;
    for (int k = 0; k < 7; k++) begin
      ye -= 7;
      run_frame(0, 0, 1, 0, 7, 632, ye, 0, 10);
    end
    run_frame(0, 0, 1, 0, 6, 632, 2, 0, 9);
    run_frame(0, 0, 1, 0, 7, 632, 0, 0, 5);

    // second tick while busy is dropped
    base = done_cnt;
    @(negedge clk);
    {dir_right, dir_left, dir_up, dir_down} = 4'b0001;
    speed = 3'd3;
    frame_tick = 1'b1;
    e = '{x: 632, y: 3, hit: 0, lat: 6, tc: cyc};
    sbq.push_back(e);
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    wait_drain();
    repeat (25) @(negedge clk);
    chk("single_done", done_cnt - base, 1);

    // restart during STEP_Y aborts with no done
    base = done_cnt;
    @(negedge clk);
    {dir_right, dir_left, dir_up, dir_down} = 4'b0001;
    speed = 3'd7;
    frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    chk("rs_y_x", int'(x_ball), 40);
    chk("rs_y_y", int'(y_ball), 60);
    chk("rs_y_busy", int'(busy), 0);
    repeat (25) @(negedge clk);
    chk("rs_y_no_done", done_cnt - base, 0);

    // asynchronous reset in the middle of STEP_X
    @(negedge clk);
    {dir_right, dir_left, dir_up, dir_down} = 4'b1000;
    speed = 3'd7;
    frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", int'(x_ball), 40);
    chk("arst_y", int'(y_ball), 60);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    run_frame(1, 0, 0, 0, 5, 45, 60, 0, 8);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end
endmodule
